// File: rtl/status_flag_controller_if.sv
// Bundle of the condition-code controller's control inputs and status outputs.
// The master side is the pipeline (Execute stage / interrupt logic); the slave side
// is the flag controller itself.
interface status_flag_controller_if #(
  parameter int NEST_DEPTH = 2,
  parameter int FLAG_W     = 4
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  logic               stall;
  logic               alu_flag_we;
  logic [FLAG_W-1:0]  alu_flag_mask;
  logic [FLAG_W-1:0]  alu_new_status;
  logic               setc;
  logic               clrc;
  logic               jz_taken;
  logic               jn_taken;
  logic               jc_taken;
  logic               int_save;
  logic               rti_restore;
  logic [FLAG_W-1:0]  flags;
  logic [DEPTH_W-1:0] depth;
  logic               flags_changed;
  logic               err_overflow;
  logic               err_underflow;

  modport master (
    output stall, alu_flag_we, alu_flag_mask, alu_new_status, setc, clrc,
           jz_taken, jn_taken, jc_taken, int_save, rti_restore,
    input  flags, depth, flags_changed, err_overflow, err_underflow
  );

  modport slave (
    input  stall, alu_flag_we, alu_flag_mask, alu_new_status, setc, clrc,
           jz_taken, jn_taken, jc_taken, int_save, rti_restore,
    output flags, depth, flags_changed, err_overflow, err_underflow
  );
endinterface

// File: rtl/status_flag_controller.sv
// Architectural condition-code register (Z,N,C,V) with a LIFO shadow stack for
// interrupt save / RTI restore. One sequenced update per cycle:
// restore -> masked ALU merge -> SETC/CLRC -> jump-consumed clears -> push.
module status_flag_controller #(
  parameter int NEST_DEPTH = 2,
  parameter int FLAG_W     = 4
) (
  input logic                    clk,
  input logic                    rst,
  status_flag_controller_if.slave bus
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
  localparam int IDX_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int Z_BIT   = 0;
  localparam int N_BIT   = 1;
  localparam int C_BIT   = 2;

  logic [FLAG_W-1:0]  flags_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               changed_q;
  logic               overflow_q;
  logic               underflow_q;
  logic [FLAG_W-1:0]  stack [NEST_DEPTH];

  logic               pop_ok;
  logic               push_ok;
  logic               overflow_hit;
  logic               underflow_hit;
  logic [DEPTH_W-1:0] depth_after_pop;
  logic [DEPTH_W-1:0] depth_next;
  logic [IDX_W-1:0]   top_idx;
  logic [FLAG_W-1:0]  flags_next;

  // Next CCR value, stack pointer movement and error events for this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    pop_ok        = 1'b0;
    push_ok       = 1'b0;
    overflow_hit  = 1'b0;
    underflow_hit = 1'b0;
    flags_next    = flags_q;

    pop_ok        = bus.rti_restore && (depth_q != '0);
    underflow_hit = bus.rti_restore && (depth_q == '0);
    depth_after_pop = pop_ok ? (depth_q - DEPTH_W'(1)) : depth_q;
    // After a pop the freed slot is both the popped entry and the next push slot.
    top_idx       = IDX_W'(depth_after_pop);

    if (pop_ok) begin
      flags_next = stack[top_idx];
    end else if (bus.alu_flag_we) begin
      // A restoring RTI owns the whole CCR; the ALU merge only applies otherwise.
      flags_next = (flags_q & ~bus.alu_flag_mask) | (bus.alu_new_status & bus.alu_flag_mask);
    end

    if (bus.setc) begin
      flags_next[C_BIT] = 1'b1;
    end else if (bus.clrc) begin
      flags_next[C_BIT] = 1'b0;
    end

    // Taken conditional jumps consume their flag, even one SETC just raised.
    if (bus.jz_taken) flags_next[Z_BIT] = 1'b0;
    if (bus.jn_taken) flags_next[N_BIT] = 1'b0;
    if (bus.jc_taken) flags_next[C_BIT] = 1'b0;

    push_ok      = bus.int_save && (depth_after_pop < DEPTH_W'(NEST_DEPTH));
    overflow_hit = bus.int_save && !push_ok;
    depth_next   = depth_after_pop + DEPTH_W'(push_ok);
  end

  // Register update: reset beats stall, stall freezes everything but the change pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      flags_q     <= '0;
      depth_q     <= '0;
      changed_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      // NOTE: the shadow stack is explicitly cleared on reset, so it is built from flops, not RAM.
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (bus.stall) begin
      changed_q <= 1'b0;
    end else begin
      flags_q     <= flags_next;
      depth_q     <= depth_next;
      changed_q   <= (flags_next != flags_q);
      overflow_q  <= overflow_q | overflow_hit;
      underflow_q <= underflow_q | underflow_hit;
      if (push_ok) begin
        stack[top_idx] <= flags_next;
      end
    end
  end

  assign bus.flags         = flags_q;
  assign bus.depth         = depth_q;
  assign bus.flags_changed = changed_q;
  assign bus.err_overflow  = overflow_q;
  assign bus.err_underflow = underflow_q;
endmodule
